karatsuba_seq_ctrl: RTL

- Multi-cycle, area-reduced counterpart of the overlap-free two-level Karatsuba multiplier.
- Computes the unsigned product A*B (N=32 bits, split into K=4 digits of M=8 bits, r=2^M) using one time-shared booth sub-multiplier instead of twelve.
- A step sequencer feeds that multiplier the twelve digit-pair products one per cycle and accumulates them into three partial sums G0/G1/G2. The partial sums are then combined as G2*r^2 + (G1-G0-G2)*r + G0.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.

---
 rtl/karatsuba_seq_ctrl_pkg.sv | 47 ++++
 rtl/karatsuba_seq_ctrl_booth.sv | 61 ++++++
 rtl/karatsuba_seq_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/karatsuba_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl_pkg
// Shared constants and types for the sequential two-level Karatsuba
// multiplier controller.
//   - DIGIT_W / NDIGITS / OPER_W : digit width, digit count, operand width
//   - SUBOP_W / SUBPROD_W        : booth sub-multiplier operand/product width
//   - NSTEPS                     : number of digit-pair products per operation
//   - state_e                    : controller state encoding
//   - Q_A_HI / Q_B_HI            : per-q half selection (bit q set = hi half)
//   - q_weight_shift()           : per-q weight as a left-shift amount
// ---------------------------------------------------------------------------
package karatsuba_seq_ctrl_pkg;

  localparam int DIGIT_W   = 8;
  localparam int NDIGITS   = 4;
  localparam int OPER_W    = DIGIT_W * NDIGITS;
  localparam int SUBOP_W   = DIGIT_W + 2;
  localparam int SUBPROD_W = 2 * DIGIT_W + 4;
  localparam int NSTEPS    = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMBINE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Half-pair per q: q0 (lo,lo), q1 (hi,hi), q2 (lo,hi), q3 (hi,lo).
  // Bit q of each mask says whether that operand uses its hi half.
  localparam logic [3:0] Q_A_HI = 4'b1010;
  localparam logic [3:0] Q_B_HI = 4'b0110;

  // Weight of a half-pair product: q0 -> 1, q1 -> r^4, q2/q3 -> r^2,
  // expressed as a shift in units of the digit width m.
  function automatic int unsigned q_weight_shift(input logic [1:0] q,
                                                 input int unsigned m);
    int unsigned sh;
    sh = 0;
    case (q)
      2'd0:    sh = 0;
      2'd1:    sh = 4 * m;
      default: sh = 2 * m;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/karatsuba_seq_ctrl_booth.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl_booth
// Combinational radix-4 Booth multiplier for two's-complement operands.
//   a_i [W-1:0]  multiplicand
//   b_i [W-1:0]  multiplier
//   p_o [PW-1:0] product (PW must equal 2*W, W must be even)
// ---------------------------------------------------------------------------
module karatsuba_seq_ctrl_booth
  import karatsuba_seq_ctrl_pkg::*;
#(
  parameter int W  = SUBOP_W,
  parameter int PW = SUBPROD_W
) (
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic [PW-1:0] p_o
);

  localparam int NPP = W / 2;

  logic [W:0]    b_pad;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] a_ext2;
  logic [PW-1:0] pp [NPP];

  // Implicit zero below the LSB starts the first Booth triplet.
  assign b_pad  = {b_i, 1'b0};
  assign a_ext  = {{(PW - W){a_i[W-1]}}, a_i};
  assign a_ext2 = a_ext << 1;

  genvar gi;
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_pp
      logic [2:0]    trip;
      logic [PW-1:0] mag;

      assign trip = b_pad[2*gi +: 3];

      always_comb begin
        mag = '0;
        case (trip)
          3'b001, 3'b010: mag = a_ext;
          3'b011:         mag = a_ext2;
          3'b100:         mag = -a_ext2;
          3'b101, 3'b110: mag = -a_ext;
          default:        mag = '0;
        endcase
      end

      assign pp[gi] = mag << (2 * gi);
    end
  endgenerate

  always_comb begin
    p_o = '0;
    for (int i = 0; i < NPP; i++) begin
      p_o = p_o + pp[i];
    end
  end

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl
// Multi-cycle unsigned N x N multiplier built around one shared Booth
// sub-multiplier. Twelve digit-pair products are accumulated into partial
// sums G0/G1/G2 (one per cycle), then combined as
// G2*r^2 + (G1-G0-G2)*r + G0.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (A, B)
//   out_valid/out_ready result handshake (out = A*B, 2N bits)
//   busy                high while computing (RUN or COMBINE)
//   step                current step 0..11 in RUN, 0 otherwise
// ---------------------------------------------------------------------------
module karatsuba_seq_ctrl
  import karatsuba_seq_ctrl_pkg::*;
#(
  parameter int N = OPER_W,
  parameter int K = NDIGITS,
  parameter int M = DIGIT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy,
  output logic [3:0]     step
);

  localparam int SW = M + 2;
  localparam int PW = 2 * M + 4;
  localparam int GW = 2 * N;

  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [GW-1:0] g0_q, g0_d;
  logic [GW-1:0] g1_q, g1_d;
  logic [GW-1:0] g2_q, g2_d;
  logic [GW-1:0] out_q, out_d;

  logic [M-1:0]  a_dig [K];
  logic [M-1:0]  b_dig [K];
  logic [1:0]    g_idx;
  logic [1:0]    q_idx;
  logic [M-1:0]  xa0, xa1, xb0, xb1;
  logic [SW-1:0] op_a, op_b;
  logic [PW-1:0] sub_prod;
  logic [GW-1:0] addend;
  logic [GW-1:0] comb_mid;
  logic [GW-1:0] comb_val;

  // Digits are taken LSB-first from the latched operands.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_dig
      assign a_dig[gi] = a_q[gi*M +: M];
      assign b_dig[gi] = b_q[gi*M +: M];
    end
  endgenerate

  assign g_idx = step_q[3:2];
  assign q_idx = step_q[1:0];

  // Inner-level Karatsuba operand for a half (x1,x0): x0, x0+x1 or x1,
  // zero-extended so the signed Booth core always sees non-negative values.
  function automatic logic [SW-1:0] g_operand(input logic [1:0] g,
                                              input logic [M-1:0] x1,
                                              input logic [M-1:0] x0);
    logic [SW-1:0] r;
    case (g)
      2'd0:    r = SW'(x0);
      2'd1:    r = SW'({1'b0, x0} + {1'b0, x1});
      default: r = SW'(x1);
    endcase
    return r;
  endfunction

  always_comb begin
    xa0  = Q_A_HI[q_idx] ? a_dig[2] : a_dig[0];
    xa1  = Q_A_HI[q_idx] ? a_dig[3] : a_dig[1];
    xb0  = Q_B_HI[q_idx] ? b_dig[2] : b_dig[0];
    xb1  = Q_B_HI[q_idx] ? b_dig[3] : b_dig[1];
    op_a = '0;
    op_b = '0;
    // Sub-multiplier is quiet outside RUN.
    if (state_q == ST_RUN) begin
      op_a = g_operand(g_idx, xa1, xa0);
      op_b = g_operand(g_idx, xb1, xb0);
    end
  end

  karatsuba_seq_ctrl_booth #(
    .W  (SW),
    .PW (PW)
  ) u_booth (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (sub_prod)
  );

  assign addend = {{(GW - PW){1'b0}}, sub_prod} << q_weight_shift(q_idx, M);

  // The middle term is non-negative in exact arithmetic, so the modular
  // subtraction cannot wrap in a way that affects the final result.
  assign comb_mid = g1_q - g0_q - g2_q;
  assign comb_val = (g2_q << (2 * M)) + (comb_mid << M) + g0_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          g0_d    = '0;
          g1_d    = '0;
          g2_d    = '0;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        case (g_idx)
          2'd0:    g0_d = g0_q + addend;
          2'd1:    g1_d = g1_q + addend;
          default: g2_d = g2_q + addend;
        endcase
        if (step_q == 4'(NSTEPS - 1)) begin
          step_d  = '0;
          state_d = ST_COMBINE;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      ST_COMBINE: begin
        out_d   = comb_val;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g0_q    <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_COMBINE);
  assign step      = (state_q == ST_RUN) ? step_q : 4'd0;
  assign out       = out_q;

endmodule
